// File: rtl/cwu_pkg.sv
// Shared constants, command encoding and mode normalisation for the
// interval-timer control-word decoder.
package cwu_pkg;

  // Select-counter value that marks a read-back command
  localparam logic [1:0] SC_READBACK = 2'b11;
  // Read/write field value that marks a counter-latch command
  localparam logic [1:0] RW_LATCH    = 2'b00;

  // Bit positions inside the control word
  localparam int SC_HI     = 7;
  localparam int SC_LO     = 6;
  localparam int RW_HI     = 5;
  localparam int RW_LO     = 4;
  localparam int M_HI      = 3;
  localparam int M_LO      = 1;
  localparam int BCD_BIT   = 0;
  localparam int RB_CNT_N  = 5;  // read-back: 0 = latch count
  localparam int RB_STS_N  = 4;  // read-back: 0 = latch status
  localparam int RB_SEL_LO = 1;  // read-back: channel 0 select bit

  typedef enum logic [1:0] {
    CMD_PROG     = 2'd0,
    CMD_LATCH    = 2'd1,
    CMD_READBACK = 2'd2,
    CMD_ILLEGAL  = 2'd3
  } cw_cmd_t;

  // Modes 6 and 7 are aliases of modes 2 and 3: drop bit 2 for them
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    logic [2:0] r;
    if (m[2:1] == 2'b11) begin
      r = {1'b0, m[1:0]};
    end else begin
      r = m;
    end
    return r;
  endfunction

endpackage

// File: rtl/cw_bus_capture.sv
// Samples the CPU bus write strobe, holds the last bus value seen while the
// strobe was low, and flags a qualified control-word write on its rising edge.
module cw_bus_capture
  import cwu_pkg::*;
#(
  parameter logic [1:0] CW_ADDR = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_n,
  input  logic       cs_n,
  input  logic [1:0] addr,
  input  logic [7:0] data,
  output logic       commit,
  output logic [7:0] held_data
);

  logic       wr_q;
  logic       hold_cs_n_r;
  logic [1:0] hold_addr_r;
  logic [7:0] hold_data_r;

  // Previous-cycle sample of the write strobe; resets high so that reset
  // release can never look like a rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b1;
    end else begin
      wr_q <= wr_n;
    end
  end

  // Hold register: the last bus sample taken while the strobe is low wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cs_n_r <= 1'b0;
      hold_addr_r <= 2'b00;
      hold_data_r <= 8'h00;
    end else if (!wr_n) begin
      hold_cs_n_r <= cs_n;
      hold_addr_r <= addr;
      hold_data_r <= data;
    end else begin
      hold_cs_n_r <= hold_cs_n_r;
      hold_addr_r <= hold_addr_r;
      hold_data_r <= hold_data_r;
    end
  end

  // Rise of the strobe with a selected control-word address commits the word
  // on this very edge, so the decoder can update its registers immediately
  assign commit    = wr_n & ~wr_q & ~hold_cs_n_r & (hold_addr_r == CW_ADDR);
  assign held_data = hold_data_r;

endmodule

// File: rtl/control_word_unit.sv
// Control-word decoder for the programmable interval timer: turns committed
// control words into per-channel program words and held latch requests that
// the counters acknowledge.
module control_word_unit
  import cwu_pkg::*;
#(
  parameter int         NUM_CNT = 3,
  parameter logic [1:0] CW_ADDR = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic                 wr_n,
  input  logic [1:0]           addr,
  input  logic [7:0]           data,
  output logic [6*NUM_CNT-1:0] prog_data,
  output logic [NUM_CNT-1:0]   prog_valid,
  output logic [NUM_CNT-1:0]   latch_cnt_req,
  output logic [NUM_CNT-1:0]   latch_sts_req,
  input  logic [NUM_CNT-1:0]   latch_cnt_ack,
  input  logic [NUM_CNT-1:0]   latch_sts_ack,
  output logic                 cw_illegal
);

  logic       commit;
  logic [7:0] held_data;
  logic [1:0] sc_s;
  logic [1:0] rw_s;
  logic [2:0] mode_s;
  logic       bcd_s;
  cw_cmd_t    cmd_s;
  logic       cw_illegal_r;

  cw_bus_capture #(
    .CW_ADDR (CW_ADDR)
  ) u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_n      (wr_n),
    .cs_n      (cs_n),
    .addr      (addr),
    .data      (data),
    .commit    (commit),
    .held_data (held_data)
  );

  assign sc_s   = held_data[SC_HI:SC_LO];
  assign rw_s   = held_data[RW_HI:RW_LO];
  assign mode_s = held_data[M_HI:M_LO];
  assign bcd_s  = held_data[BCD_BIT];

  // Classify the held word; read-back with bit 0 set and absent channels are illegal
  always_comb begin
    cmd_s = CMD_ILLEGAL;
    if (sc_s == SC_READBACK) begin
      if (held_data[BCD_BIT]) begin
        cmd_s = CMD_ILLEGAL;
      end else begin
        cmd_s = CMD_READBACK;
      end
    end else if (int'(sc_s) < NUM_CNT) begin
      if (rw_s == RW_LATCH) begin
        cmd_s = CMD_LATCH;
      end else begin
        cmd_s = CMD_PROG;
      end
    end else begin
      cmd_s = CMD_ILLEGAL;
    end
  end

  // Illegal-word pulse, high only for the cycle after the committing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_illegal_r <= 1'b0;
    end else begin
      cw_illegal_r <= commit & (cmd_s == CMD_ILLEGAL);
    end
  end

  assign cw_illegal = cw_illegal_r;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    logic [5:0] word_r;
    logic       pv_r;
    logic       cnt_r;
    logic       sts_r;
    logic       sel_s;
    logic       rb_sel_s;
    logic       prog_hit_s;
    logic       cnt_set_s;
    logic       sts_set_s;

    assign sel_s      = (sc_s == 2'(i));
    assign rb_sel_s   = held_data[RB_SEL_LO + i];
    assign prog_hit_s = commit & (cmd_s == CMD_PROG) & sel_s;
    assign cnt_set_s  = commit & (((cmd_s == CMD_LATCH) & sel_s) |
                                  ((cmd_s == CMD_READBACK) & rb_sel_s & ~held_data[RB_CNT_N]));
    assign sts_set_s  = commit & (cmd_s == CMD_READBACK) & rb_sel_s & ~held_data[RB_STS_N];

    // Program word and its one-cycle valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_r <= 6'd0;
        pv_r   <= 1'b0;
      end else begin
        pv_r <= prog_hit_s;
        if (prog_hit_s) begin
          word_r <= {rw_s, norm_mode(mode_s), bcd_s};
        end else begin
          word_r <= word_r;
        end
      end
    end

    // Latch requests: programming clears, a set beats a same-edge ack,
    // and an ack alone clears on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= 1'b0;
        sts_r <= 1'b0;
      end else if (prog_hit_s) begin
        cnt_r <= 1'b0;
        sts_r <= 1'b0;
      end else begin
        if (cnt_set_s) begin
          cnt_r <= 1'b1;
        end else if (latch_cnt_ack[i]) begin
          cnt_r <= 1'b0;
        end else begin
          cnt_r <= cnt_r;
        end
        if (sts_set_s) begin
          sts_r <= 1'b1;
        end else if (latch_sts_ack[i]) begin
          sts_r <= 1'b0;
        end else begin
          sts_r <= sts_r;
        end
      end
    end

    assign prog_data[6*i +: 6] = word_r;
    assign prog_valid[i]       = pv_r;
    assign latch_cnt_req[i]    = cnt_r;
    assign latch_sts_req[i]    = sts_r;
  end

endmodule

// File: tb/tb_control_word_unit.sv
// Directed self-checking bench for control_word_unit: a three-channel
// instance plus a two-channel instance sharing the same bus.
module tb_control_word_unit;
  import cwu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [1:0]  addr = 2'b00;
  logic [7:0]  data = 8'h00;

  logic [17:0] prog_data;
  logic [2:0]  prog_valid, latch_cnt_req, latch_sts_req;
  logic [2:0]  latch_cnt_ack = 3'b000, latch_sts_ack = 3'b000;
  logic        cw_illegal;

  logic [11:0] prog_data2;
  logic [1:0]  prog_valid2, latch_cnt_req2, latch_sts_req2;
  logic [1:0]  latch_cnt_ack2 = 2'b00, latch_sts_ack2 = 2'b00;
  logic        cw_illegal2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_word_unit #(.NUM_CNT(3), .CW_ADDR(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .data(data),
    .prog_data(prog_data), .prog_valid(prog_valid),
    .latch_cnt_req(latch_cnt_req), .latch_sts_req(latch_sts_req),
    .latch_cnt_ack(latch_cnt_ack), .latch_sts_ack(latch_sts_ack),
    .cw_illegal(cw_illegal)
  );

  control_word_unit #(.NUM_CNT(2), .CW_ADDR(2'b11)) dut2 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .data(data),
    .prog_data(prog_data2), .prog_valid(prog_valid2),
    .latch_cnt_req(latch_cnt_req2), .latch_sts_req(latch_sts_req2),
    .latch_cnt_ack(latch_cnt_ack2), .latch_sts_ack(latch_sts_ack2),
    .cw_illegal(cw_illegal2)
  );

  // One low sample of wr_n, then rise; returns just after the committing edge
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic c);
    @(negedge clk);
    cs_n = c; addr = a; data = d; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (prog_data !== 18'd0) begin bad++; $display("FAIL reset_prog_data got=%h want=%h", prog_data, 18'd0); end
    total++; if ({prog_valid, latch_cnt_req, latch_sts_req, cw_illegal} !== 10'd0) begin
      bad++; $display("FAIL reset_flags got=%b want=%b", {prog_valid, latch_cnt_req, latch_sts_req, cw_illegal}, 10'd0); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({prog_valid, prog_valid2, cw_illegal, cw_illegal2} !== 7'd0) begin
      bad++; $display("FAIL reset_release_pulse got=%b want=%b", {prog_valid, prog_valid2, cw_illegal, cw_illegal2}, 7'd0); end
  endtask

  task automatic test_illegal();
    bus_write(2'b11, 8'h90, 1'b0);
    total++; if (cw_illegal2 !== 1'b1) begin bad++; $display("FAIL ill_sc2_pulse got=%b want=1", cw_illegal2); end
    total++; if ({prog_valid2, latch_cnt_req2, latch_sts_req2, prog_data2} !== 18'd0) begin
      bad++; $display("FAIL ill_sc2_state got=%h want=0", {prog_valid2, latch_cnt_req2, latch_sts_req2, prog_data2}); end
    total++; if (prog_valid !== 3'b100 || prog_data !== 18'b010000_000000_000000 || cw_illegal !== 1'b0) begin
      bad++; $display("FAIL sc2_legal_on_3ch got=%b/%b/%b want=100/010000000000000000/0", prog_valid, prog_data, cw_illegal); end
    @(posedge clk); #1;
    total++; if (cw_illegal2 !== 1'b0) begin bad++; $display("FAIL ill_pulse_width got=%b want=0", cw_illegal2); end
    bus_write(2'b11, 8'hC1, 1'b0);
    total++; if (cw_illegal !== 1'b1 || cw_illegal2 !== 1'b1) begin
      bad++; $display("FAIL ill_rb_bit0 got=%b%b want=11", cw_illegal, cw_illegal2); end
    total++; if ({prog_valid, latch_cnt_req, latch_sts_req} !== 9'd0) begin
      bad++; $display("FAIL ill_rb_state got=%b want=0", {prog_valid, latch_cnt_req, latch_sts_req}); end
    bus_write(2'b01, 8'h34, 1'b0);
    total++; if (prog_valid !== 3'b000 || prog_data !== 18'b010000_000000_000000 || cw_illegal !== 1'b0) begin
      bad++; $display("FAIL wrong_addr got=%b/%b want=000/010000000000000000", prog_valid, prog_data); end
    bus_write(2'b11, 8'h34, 1'b1);
    total++; if (prog_valid !== 3'b000 || prog_data !== 18'b010000_000000_000000 || cw_illegal !== 1'b0) begin
      bad++; $display("FAIL cs_high got=%b/%b want=000/010000000000000000", prog_valid, prog_data); end
  endtask

  task automatic test_program();
    bus_write(2'b11, 8'h34, 1'b0);
    total++; if (prog_valid !== 3'b001) begin bad++; $display("FAIL prog_valid got=%b want=001", prog_valid); end
    total++; if (prog_data !== 18'b010000_000000_110100) begin
      bad++; $display("FAIL prog_data got=%b want=010000000000110100", prog_data); end
    @(posedge clk); #1;
    total++; if (prog_valid !== 3'b000) begin bad++; $display("FAIL prog_valid_width got=%b want=000", prog_valid); end
  endtask

  task automatic test_mode_norm();
    bus_write(2'b11, 8'h9E, 1'b0);
    total++; if (prog_valid !== 3'b100 || prog_data[17:12] !== 6'b010110) begin
      bad++; $display("FAIL mode7 got=%b/%b want=100/010110", prog_valid, prog_data[17:12]); end
    bus_write(2'b11, 8'h5D, 1'b0);
    total++; if (prog_valid !== 3'b010 || prog_data[11:6] !== 6'b010101) begin
      bad++; $display("FAIL mode6 got=%b/%b want=010/010101", prog_valid, prog_data[11:6]); end
    bus_write(2'b11, 8'h1A, 1'b0);
    total++; if (prog_data !== 18'b010110_010101_011010) begin
      bad++; $display("FAIL mode5 got=%b want=010110010101011010", prog_data); end
  endtask

  task automatic test_latch();
    bus_write(2'b11, 8'h40, 1'b0);
    total++; if (latch_cnt_req !== 3'b010) begin bad++; $display("FAIL latch_set got=%b want=010", latch_cnt_req); end
    bus_write(2'b11, 8'h40, 1'b0);
    total++; if (latch_cnt_req !== 3'b010 || prog_valid !== 3'b000) begin
      bad++; $display("FAIL latch_again got=%b/%b want=010/000", latch_cnt_req, prog_valid); end
    @(negedge clk); latch_cnt_ack = 3'b010;
    @(posedge clk); #1;
    total++; if (latch_cnt_req !== 3'b000) begin bad++; $display("FAIL latch_ack got=%b want=000", latch_cnt_req); end
    @(negedge clk); latch_cnt_ack = 3'b000;
    bus_write(2'b11, 8'h40, 1'b0);
    // request pending; set and ack now land on the same edge
    @(negedge clk);
    data = 8'h40; addr = 2'b11; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1; latch_cnt_ack = 3'b010;
    @(posedge clk); #1;
    total++; if (latch_cnt_req !== 3'b010) begin bad++; $display("FAIL set_beats_ack got=%b want=010", latch_cnt_req); end
    @(negedge clk); latch_cnt_ack = 3'b000;
    @(posedge clk); #1;
    total++; if (latch_cnt_req !== 3'b010) begin bad++; $display("FAIL latch_hold got=%b want=010", latch_cnt_req); end
    @(negedge clk); latch_cnt_ack = 3'b111;
    @(posedge clk); #1;
    total++; if (latch_cnt_req !== 3'b000) begin bad++; $display("FAIL latch_clear got=%b want=000", latch_cnt_req); end
    @(negedge clk); latch_cnt_ack = 3'b000;
  endtask

  task automatic test_readback();
    bus_write(2'b11, 8'hC6, 1'b0);
    total++; if (latch_cnt_req !== 3'b011 || latch_sts_req !== 3'b011) begin
      bad++; $display("FAIL rb_both got=%b/%b want=011/011", latch_cnt_req, latch_sts_req); end
    bus_write(2'b11, 8'h30, 1'b0);
    total++; if (latch_cnt_req !== 3'b010 || latch_sts_req !== 3'b010 || prog_data[5:0] !== 6'b110000) begin
      bad++; $display("FAIL prog_clears got=%b/%b/%b want=010/010/110000", latch_cnt_req, latch_sts_req, prog_data[5:0]); end
    bus_write(2'b11, 8'hE8, 1'b0);
    total++; if (latch_cnt_req !== 3'b010 || latch_sts_req !== 3'b110) begin
      bad++; $display("FAIL rb_sts_only got=%b/%b want=010/110", latch_cnt_req, latch_sts_req); end
    bus_write(2'b11, 8'hFE, 1'b0);
    total++; if (latch_cnt_req !== 3'b010 || latch_sts_req !== 3'b110 || cw_illegal !== 1'b0) begin
      bad++; $display("FAIL rb_noop got=%b/%b/%b want=010/110/0", latch_cnt_req, latch_sts_req, cw_illegal); end
    @(negedge clk); latch_sts_ack = 3'b111; latch_cnt_ack = 3'b010;
    @(posedge clk); #1;
    total++; if (latch_cnt_req !== 3'b000 || latch_sts_req !== 3'b000) begin
      bad++; $display("FAIL rb_ack got=%b/%b want=000/000", latch_cnt_req, latch_sts_req); end
    @(negedge clk); latch_sts_ack = 3'b000; latch_cnt_ack = 3'b000;
  endtask

  task automatic test_back_to_back();
    bus_write(2'b11, 8'h34, 1'b0);
    total++; if (prog_valid !== 3'b001) begin bad++; $display("FAIL b2b_first got=%b want=001", prog_valid); end
    bus_write(2'b11, 8'h76, 1'b0);
    total++; if (prog_valid !== 3'b010 || prog_data !== 18'b010110_110110_110100) begin
      bad++; $display("FAIL b2b_second got=%b/%b want=010/010110110110110100", prog_valid, prog_data); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    cs_n = 1'b0; addr = 2'b11; data = 8'h12; wr_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (prog_data !== 18'd0 || {prog_valid, latch_cnt_req, latch_sts_req, cw_illegal} !== 10'd0) begin
      bad++; $display("FAIL midwrite_reset got=%b want=0", prog_data); end
    wr_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (prog_valid !== 3'b000 || prog_data !== 18'd0 || cw_illegal !== 1'b0) begin
        bad++; $display("FAIL midwrite_commit got=%b/%b want=000/0", prog_valid, prog_data); end
    end
    cs_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_program();
    test_mode_norm();
    test_latch();
    test_readback();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
